pcpu_mem_responder: RTL and testbench
=====================================

Name: pcpu_mem_responder

Overview:
Memory-side responder for the stall-handling pipelined RV32 core. It serves the core's instruction-fetch port and data-memory port: asynchronous word reads and synchronous writes. It also exposes a small MMIO window with an LED register, a free-running cycle counter, status flags and a byte TX FIFO that drains over a valid/ready handshake. It sits beside the core in the lab top level, between the core and board I/O.

Parameters:
IMEM_WORDS, 1024, instruction memory depth in 32-bit words (power of 2)
DMEM_WORDS, 1024, data memory depth in 32-bit words (power of 2)
FIFO_DEPTH, 8, TX FIFO depth in bytes (power of 2, >=2)
MMIO_BASE, 32'hF000_0000, base byte address of the 16-byte MMIO window

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-low
PC_in  in  32  fetch byte address from core
inst_out  out  32  instruction word at PC_in
Addr_in  in  32  data byte address from core Mem stage
Wdata_in  in  32  store data from core
MemRW  in  1  1 = write this cycle, 0 = read
Rdata_out  out  32  load data to core
imem_we  in  1  loader write enable for IMEM
imem_waddr  in  32  loader word index
imem_wdata  in  32  loader write data
led_out  out  16  LED register
tx_data  out  8  FIFO head byte
tx_valid  out  1  FIFO non-empty
tx_ready  in  1  downstream accepts head byte
fault  out  1  sticky access-fault flag
fault_addr  out  32  Addr_in of the first fault since last clear

Behaviour:
- Reset: clk and rst are the only clock and reset; reset is synchronous and active-low. While rst=0 at an edge, the following take the stated values at that edge:
  - led_out=0, cycle counter=0, fault=0, fault_addr=0, overflow=0.
  - FIFO is empty: rd_ptr=wr_ptr=count=0, so tx_valid=0.
  - tx_data=0 when the FIFO is empty.
  - IMEM/DMEM contents are not cleared.
  - A reset mid-transfer discards all queued bytes.
- Fetch: inst_out is combinational from IMEM[PC_in[..:2]].
  - If PC_in[1:0]!=0 or the word index is >= IMEM_WORDS, inst_out=32'h0000_0013 (NOP).
  - Loader write is synchronous on imem_we; it is ignored if imem_waddr >= IMEM_WORDS.
  - A read of the same word in the write cycle returns the old data.
- Address decode, combinational on Addr_in:
  - DMEM when word index < DMEM_WORDS.
  - MMIO when Addr_in[31:4]==MMIO_BASE[31:4].
  - Anything else is unmapped.
- Reads (always active, since the core drives ALU results on Addr_in every cycle):
  - Rdata_out is combinational.
  - DMEM returns the word.
  - MMIO returns the register below.
  - Unmapped returns 0.
  - Reads never fault.
- Writes (MemRW=1), committed at the clock edge:
  - DMEM word write.
  - Misaligned address (Addr_in[1:0]!=0) or unmapped address: write suppressed. If fault=0, set fault=1 and latch fault_addr=Addr_in; otherwise keep the first fault_addr.
- MMIO map (offsets):
  - +0x0 LED: RW; write loads Wdata_in[15:0]; read returns {16'b0, led}.
  - +0x4 CYCLE: RO; increments by 1 every cycle out of reset; wraps 0xFFFF_FFFF -> 0; writes ignored, no fault.
  - +0x8 TX: WO; write pushes Wdata_in[7:0]; read returns 0.
  - +0xC STATUS: read returns {28'b0, overflow, fault, full, empty}. Write is write-1-to-clear: bit3 clears overflow, bit2 clears fault and zeroes fault_addr. A new fault in the clear cycle wins: fault=1 and fault_addr=new address.
- TX FIFO:
  - tx_valid = (count!=0); tx_data = mem[rd_ptr].
  - Pop on tx_valid && tx_ready.
  - Push accepted if count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop occurs in the same cycle. Otherwise the byte is dropped and overflow=1.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
  - A pushed byte appears on tx_data no earlier than the next cycle (1-cycle latency into an empty FIFO).
  - tx_data/tx_valid are stable while tx_valid=1 and tx_ready=0.
  - full = (count==FIFO_DEPTH); empty = (count==0).

Test Plan:
- Reset/fetch:
  - Hold rst=0 for 2 cycles, then release; load IMEM[1]=32'h00500093. Expect inst_out=32'h00500093 at PC_in=4.
  - Expect inst_out=32'h00000013 at PC_in=6 and at PC_in=IMEM_WORDS*4.
  - After reset: led_out=0, tx_valid=0, fault=0.
- DMEM and fault:
  - Write 32'hDEADBEEF to 0x10; Rdata_out=32'hDEADBEEF at 0x10 next cycle.
  - Write to 0x12: DMEM unchanged, fault=1, fault_addr=0x12.
  - Second bad write to 0x20000000: fault_addr stays 0x12.
  - Write 4 to STATUS: fault=0, fault_addr=0.
- Cycle counter: read CYCLE twice, 5 cycles apart -> difference exactly 5.
- FIFO fill/overflow (tx_ready=0):
  - Push 0x41..0x48 -> full=1, tx_data=0x41.
  - Push 0x49 -> dropped, overflow=1, STATUS=4'b1010.
  - Write 8 to STATUS -> overflow=0.
- FIFO drain and wrap:
  - tx_ready=1 -> bytes 0x41..0x48 emerge in order, one per cycle; then tx_valid=0, empty=1.
  - Refill 3 bytes across the pointer wrap -> correct order.
- Full with simultaneous push/pop: full, tx_ready=1, push 0x5A -> 0x5A accepted, count stays 8, overflow=0, 0x5A emerges last.

Source files
------------

// File: rtl/pcpu_mem_responder_if.sv
// Core-side memory bus: instruction fetch port plus data-memory port.
// The core drives addresses and store data; the responder returns words.
interface pcpu_mem_responder_if;
    logic [31:0] PC_in;
    logic [31:0] inst_out;
    logic [31:0] Addr_in;
    logic [31:0] Wdata_in;
    logic        MemRW;
    logic [31:0] Rdata_out;

    modport master (
        output PC_in,
        output Addr_in,
        output Wdata_in,
        output MemRW,
        input  inst_out,
        input  Rdata_out
    );

    modport slave (
        input  PC_in,
        input  Addr_in,
        input  Wdata_in,
        input  MemRW,
        output inst_out,
        output Rdata_out
    );
endinterface

// File: rtl/pcpu_mem_responder.sv
// Memory-side responder for the pipelined RV32 core: IMEM with loader port,
// DMEM with async read / sync write, and a 16-byte MMIO window holding the
// LED register, a free-running cycle counter, a byte TX FIFO and status.
module pcpu_mem_responder #(
    parameter int          IMEM_WORDS = 1024,
    parameter int          DMEM_WORDS = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hF000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    pcpu_mem_responder_if.slave   bus,
    input  logic                  imem_we,
    input  logic [31:0]           imem_waddr,
    input  logic [31:0]           imem_wdata,
    output logic [15:0]           led_out,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  fault,
    output logic [31:0]           fault_addr
);
    localparam int          IW      = $clog2(IMEM_WORDS);
    localparam int          DW      = $clog2(DMEM_WORDS);
    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];
    logic [7:0]  fifo [FIFO_DEPTH];

    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic [31:0]   cycle_cnt;
    logic          overflow;

    logic        aligned, dmem_hit, mmio_hit, wr_ok, wr_bad;
    logic [1:0]  reg_sel;
    logic        sts_wr, led_wr, push_req, push_ok, pop, fault_clr;

    // Fetch: misaligned or out-of-range PCs see a NOP instead of aliasing.
    always_comb begin
        bus.inst_out = NOP;
        if (bus.PC_in[1:0] == 2'b00 && bus.PC_in[31:2] < 30'(IMEM_WORDS))
            bus.inst_out = imem[bus.PC_in[IW+1:2]];
    end

    // Loader port; indices past the end are dropped rather than wrapped.
    always_ff @(posedge clk) begin
        if (imem_we && imem_waddr < 32'(IMEM_WORDS))
            imem[imem_waddr[IW-1:0]] <= imem_wdata;
    end

    assign aligned  = (bus.Addr_in[1:0] == 2'b00);
    assign dmem_hit = (bus.Addr_in[31:2] < 30'(DMEM_WORDS));
    assign mmio_hit = (bus.Addr_in[31:4] == MMIO_BASE[31:4]);
    assign reg_sel  = bus.Addr_in[3:2];

    assign wr_ok     = bus.MemRW && aligned && (dmem_hit || mmio_hit);
    assign wr_bad    = bus.MemRW && !(aligned && (dmem_hit || mmio_hit));
    assign led_wr    = wr_ok && mmio_hit && !dmem_hit && reg_sel == 2'd0;
    assign push_req  = wr_ok && mmio_hit && !dmem_hit && reg_sel == 2'd2;
    assign sts_wr    = wr_ok && mmio_hit && !dmem_hit && reg_sel == 2'd3;
    assign fault_clr = sts_wr && bus.Wdata_in[2];

    assign tx_valid = (count != '0);
    assign tx_data  = tx_valid ? fifo[rd_ptr] : 8'h00;
    assign pop      = tx_valid && tx_ready;
    // A full FIFO can still take a byte when the head leaves in the same cycle.
    assign push_ok  = push_req && (count != DEPTH_C || pop);

    // Read mux: reads are side-effect free and never fault.
    always_comb begin
        bus.Rdata_out = 32'h0;
        if (dmem_hit) begin
            bus.Rdata_out = dmem[bus.Addr_in[DW+1:2]];
        end else if (mmio_hit) begin
            case (reg_sel)
                2'd0:    bus.Rdata_out = {16'h0, led_out};
                2'd1:    bus.Rdata_out = cycle_cnt;
                2'd3:    bus.Rdata_out = {28'h0, overflow, fault,
                                          count == DEPTH_C, count == '0};
                default: bus.Rdata_out = 32'h0;
            endcase
        end
    end

    // DMEM store port; contents survive reset but no stores land during it.
    always_ff @(posedge clk) begin
        if (rst && wr_ok && dmem_hit)
            dmem[bus.Addr_in[DW+1:2]] <= bus.Wdata_in;
    end

    // FIFO storage; head is masked while empty so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push_ok)
            fifo[wr_ptr] <= bus.Wdata_in[7:0];
    end

    // Control registers, FIFO pointers and the sticky fault/overflow flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            led_out    <= 16'h0;
            cycle_cnt  <= 32'h0;
            fault      <= 1'b0;
            fault_addr <= 32'h0;
            overflow   <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (led_wr)
                led_out <= bus.Wdata_in[15:0];

            if (fault_clr) begin
                fault      <= 1'b0;
                fault_addr <= 32'h0;
            end
            // A new fault in the clearing cycle takes precedence over the clear.
            if (wr_bad && (!fault || fault_clr)) begin
                fault      <= 1'b1;
                fault_addr <= bus.Addr_in;
            end

            if (sts_wr && bus.Wdata_in[3])
                overflow <= 1'b0;
            if (push_req && !push_ok)
                overflow <= 1'b1;

            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_pcpu_mem_responder.sv
// Directed plus randomized bench for pcpu_mem_responder against a
// queue/array reference model.
module tb_pcpu_mem_responder;
    localparam int          IMEM_WORDS = 1024;
    localparam int          DMEM_WORDS = 1024;
    localparam int          FIFO_DEPTH = 8;
    localparam logic [31:0] MMIO  = 32'hF000_0000;
    localparam logic [31:0] A_LED = 32'hF000_0000;
    localparam logic [31:0] A_CYC = 32'hF000_0004;
    localparam logic [31:0] A_TX  = 32'hF000_0008;
    localparam logic [31:0] A_STS = 32'hF000_000C;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_we = 1'b0;
    logic [31:0] imem_waddr = '0, imem_wdata = '0;
    logic [15:0] led_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        fault;
    logic [31:0] fault_addr;

    pcpu_mem_responder_if bus();

    pcpu_mem_responder dut (
        .clk(clk), .rst(rst), .bus(bus),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .led_out(led_out), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .fault(fault), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] m_dmem [DMEM_WORDS];
    bit          m_dv   [DMEM_WORDS];
    logic [31:0] m_imem [IMEM_WORDS];
    bit          m_iv   [IMEM_WORDS];
    logic [15:0] m_led = '0;
    logic [31:0] m_cycle = '0, m_faddr = '0;
    bit          m_fault = 0, m_ovf = 0;
    logic [7:0]  q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_mmio(input logic [31:0] a);
        return (a & 32'hFFFF_FFF0) == MMIO;
    endfunction

    function automatic bit is_dmem(input logic [31:0] a);
        return (a >> 2) < DMEM_WORDS;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        logic [31:0] r = 32'h0;
        if (is_dmem(a)) r = m_dmem[int'(a >> 2)];
        else if (is_mmio(a)) begin
            case (a & 32'hC)
                32'h0:   r = {16'h0, m_led};
                32'h4:   r = m_cycle;
                32'hC:   r = {28'h0, m_ovf, m_fault, q.size() == FIFO_DEPTH, q.size() == 0};
                default: r = 32'h0;
            endcase
        end
        return r;
    endfunction

    function automatic bit rd_known(input logic [31:0] a);
        return !is_dmem(a) || m_dv[int'(a >> 2)];
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_edge();
        logic [31:0] a = bus.Addr_in;
        logic [31:0] d = bus.Wdata_in;
        int  sz = q.size();
        bit  pop;
        bit  good;
        if (imem_we && imem_waddr < 32'(IMEM_WORDS)) begin
            m_imem[int'(imem_waddr)] = imem_wdata;
            m_iv[int'(imem_waddr)] = 1;
        end
        if (!rst) begin
            m_led = '0; m_cycle = '0; m_fault = 0; m_faddr = '0; m_ovf = 0;
            q.delete();
            return;
        end
        m_cycle++;
        pop = (sz > 0) && tx_ready;
        if (pop) void'(q.pop_front());
        if (bus.MemRW) begin
            good = (a[1:0] == 2'b00) && (is_dmem(a) || is_mmio(a));
            if (!good) begin
                if (!m_fault) begin m_fault = 1; m_faddr = a; end
            end else if (is_dmem(a)) begin
                m_dmem[int'(a >> 2)] = d;
                m_dv[int'(a >> 2)] = 1;
            end else if (a == A_LED) m_led = d[15:0];
            else if (a == A_TX) begin
                if (sz < FIFO_DEPTH || pop) q.push_back(d[7:0]);
                else m_ovf = 1;
            end else if (a == A_STS) begin
                if (d[3]) m_ovf = 0;
                if (d[2]) begin m_fault = 0; m_faddr = '0; end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        #1;
        chk({tag, "_led"}, {16'h0, led_out}, {16'h0, m_led});
        chk({tag, "_txv"}, {31'h0, tx_valid}, {31'h0, q.size() != 0});
        chk({tag, "_txd"}, {24'h0, tx_data}, {24'h0, (q.size() != 0) ? q[0] : 8'h00});
        chk({tag, "_flt"}, {31'h0, fault}, {31'h0, m_fault});
        chk({tag, "_fad"}, fault_addr, m_faddr);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.Addr_in = a; bus.Wdata_in = d; bus.MemRW = 1'b1;
        tick();
        bus.MemRW = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.Addr_in = a; bus.MemRW = 1'b0;
        #1;
        chk(tag, bus.Rdata_out, exp);
    endtask

    task automatic load(input int idx, input logic [31:0] d);
        imem_we = 1'b1; imem_waddr = 32'(idx); imem_wdata = d;
        tick();
        imem_we = 1'b0;
    endtask

    logic [31:0] c0, c1, a, pc;

    initial begin
        bus.PC_in = '0; bus.Addr_in = '0; bus.Wdata_in = '0; bus.MemRW = 1'b0;

        // Reset and idle state
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        check_state("rst");
        chk("rst_led", {16'h0, led_out}, 32'h0);
        chk("rst_txv", {31'h0, tx_valid}, 32'h0);
        chk("rst_flt", {31'h0, fault}, 32'h0);
        rd_chk("rst_sts", A_STS, 32'h1);
        rd_chk("rst_cyc", A_CYC, 32'h0);

        // Fetch, loader bounds and old-data-on-write
        load(1, 32'h0050_0093);
        bus.PC_in = 32'd4; #1;
        chk("fetch_4", bus.inst_out, 32'h0050_0093);
        bus.PC_in = 32'd6; #1;
        chk("fetch_mis", bus.inst_out, NOP);
        bus.PC_in = 32'(IMEM_WORDS * 4); #1;
        chk("fetch_oor", bus.inst_out, NOP);
        load(0, 32'h1111_1111);
        load(IMEM_WORDS, 32'hBAD0_BAD0);
        bus.PC_in = 32'd0; #1;
        chk("fetch_ldr_oor", bus.inst_out, 32'h1111_1111);
        bus.PC_in = 32'd4;
        imem_we = 1'b1; imem_waddr = 32'd1; imem_wdata = 32'h2222_2222; #1;
        chk("fetch_old", bus.inst_out, 32'h0050_0093);
        tick();
        imem_we = 1'b0; #1;
        chk("fetch_new", bus.inst_out, 32'h2222_2222);

        // DMEM and fault capture
        wr(32'h10, 32'hDEAD_BEEF);
        rd_chk("dmem_rd", 32'h10, 32'hDEAD_BEEF);
        wr(32'h12, 32'h1234_5678);
        rd_chk("dmem_mis_keep", 32'h10, 32'hDEAD_BEEF);
        chk("flt_set", {31'h0, fault}, 32'h1);
        chk("flt_addr", fault_addr, 32'h12);
        wr(32'h2000_0000, 32'h1);
        chk("flt_first", fault_addr, 32'h12);
        wr(A_STS, 32'h4);
        chk("flt_clr", {31'h0, fault}, 32'h0);
        chk("flt_clr_addr", fault_addr, 32'h0);
        wr(32'(DMEM_WORDS * 4), 32'h5);
        chk("flt_dmem_end", fault_addr, 32'(DMEM_WORDS * 4));
        wr(A_STS, 32'h4);
        check_state("dmem");

        // Cycle counter, LED, read-only and write-only registers
        rd_chk("cyc_model", A_CYC, m_cycle);
        c0 = bus.Rdata_out;
        repeat (5) tick();
        #1;
        c1 = bus.Rdata_out;
        chk("cyc_diff", c1 - c0, 32'd5);
        wr(A_LED, 32'hABCD_1234);
        chk("led_out", {16'h0, led_out}, 32'h1234);
        rd_chk("led_rd", A_LED, 32'h0000_1234);
        wr(A_CYC, 32'h0);
        chk("cyc_wr_nofault", {31'h0, fault}, 32'h0);
        rd_chk("tx_rd0", A_TX, 32'h0);
        rd_chk("unmapped_rd", 32'h2000_0040, 32'h0);

        // FIFO fill, latency, overflow
        tx_ready = 1'b0;
        bus.Addr_in = A_TX; bus.Wdata_in = 32'h41; bus.MemRW = 1'b1; #1;
        chk("lat_empty", {31'h0, tx_valid}, 32'h0);
        tick(); bus.MemRW = 1'b0;
        for (int i = 1; i < 8; i++) wr(A_TX, 32'h41 + 32'(i));
        rd_chk("fifo_full", A_STS, 32'b0010);
        chk("fifo_head", {24'h0, tx_data}, 32'h41);
        wr(A_TX, 32'h49);
        rd_chk("fifo_ovf", A_STS, 32'b1010);
        chk("fifo_head_stable", {24'h0, tx_data}, 32'h41);
        wr(A_STS, 32'h8);
        rd_chk("ovf_clr", A_STS, 32'b0010);

        // Drain in order
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("drain_v", {31'h0, tx_valid}, 32'h1);
            chk("drain_d", {24'h0, tx_data}, 32'h41 + 32'(i));
            tick();
        end
        chk("drain_done", {31'h0, tx_valid}, 32'h0);
        rd_chk("drain_sts", A_STS, 32'b0001);

        // Move pointers to 6, then push 3 across the wrap
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) wr(A_TX, 32'h31 + 32'(i));
        tx_ready = 1'b1;
        repeat (6) tick();
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) wr(A_TX, 32'h71 + 32'(i));
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wrap_d", {24'h0, tx_data}, 32'h71 + 32'(i));
            tick();
        end
        chk("wrap_done", {31'h0, tx_valid}, 32'h0);

        // Full with simultaneous push and pop
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(A_TX, 32'h61 + 32'(i));
        tx_ready = 1'b1;
        wr(A_TX, 32'h5A);
        tx_ready = 1'b0;
        rd_chk("pp_full", A_STS, 32'b0010);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("pp_d", {24'h0, tx_data}, (i == 7) ? 32'h5A : 32'h62 + 32'(i));
            tick();
        end
        check_state("pp_end");

        // Randomized traffic against the model
        for (int it = 0; it < 400; it++) begin
            int op = $urandom_range(0, 9);
            rst = ($urandom_range(0, 79) != 0);
            tx_ready = $urandom_range(0, 1);
            imem_we = ($urandom_range(0, 3) == 0);
            imem_waddr = $urandom_range(0, 1) ? 32'($urandom_range(0, 7))
                                              : 32'(IMEM_WORDS + $urandom_range(0, 7));
            imem_wdata = $urandom;
            case ($urandom_range(0, 2))
                0:       pc = 32'(IMEM_WORDS * 4) + 32'($urandom_range(0, 7) * 4);
                1:       pc = 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(1, 3));
                default: pc = 32'($urandom_range(0, 7) * 4);
            endcase
            bus.PC_in = pc;
            bus.Wdata_in = $urandom;
            bus.MemRW = 1'b1;
            case (op)
                0, 1: a = 32'($urandom_range(0, 15) * 4);
                2:    a = A_LED;
                3, 4: a = A_TX;
                5:    a = A_STS;
                6:    a = ($urandom_range(0, 1) ? 32'h40 : MMIO) + 32'($urandom_range(1, 3));
                7:    a = $urandom_range(0, 3) == 0 ? 32'(DMEM_WORDS * 4)
                                                    : 32'h2000_0000 + 32'($urandom_range(0, 255) * 4);
                8:    a = A_CYC;
                default: begin
                    bus.MemRW = 1'b0;
                    case ($urandom_range(0, 2))
                        0:       a = 32'($urandom_range(0, 63));
                        1:       a = MMIO + 32'($urandom_range(0, 15));
                        default: a = 32'h8000_0000 + 32'($urandom_range(0, 63));
                    endcase
                end
            endcase
            bus.Addr_in = a;
            #1;
            if (rd_known(a)) chk("rnd_rd", bus.Rdata_out, exp_rd(a));
            if ((pc & 32'h3) != 0 || (pc >> 2) >= IMEM_WORDS)
                chk("rnd_nop", bus.inst_out, NOP);
            else if (m_iv[int'(pc >> 2)])
                chk("rnd_inst", bus.inst_out, m_imem[int'(pc >> 2)]);
            tick();
            bus.MemRW = 1'b0;
            imem_we = 1'b0;
            rst = 1'b1;
            check_state("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
